// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: op codes, default width and FSM states shared by the multiply/divide unit
package mult_div_unit_pkg;
    localparam int DEF_WIDTH = 32;
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: conditional two's-complement negate, serving as abs() on operands and sign fix on results
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);
    assign y = neg ? -a : a;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed/unsigned MULT/DIV into HI/LO, single-cycle MTHI/MTLO
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_mul, neg_q, neg_r;
    logic [WIDTH-1:0]   m, rem, rs_abs, rt_abs, rem_fix;
    logic [2*WIDTH-1:0] acc, acc_fix;
    logic [WIDTH:0]     msum, shl, diff;
    logic               mul_op, div_op, sgn;

    assign mul_op = op == OP_MULT || op == OP_MULTU;
    assign div_op = op == OP_DIV || op == OP_DIVU;
    assign sgn    = op == OP_MULT || op == OP_DIV;
    assign busy   = state != IDLE;
    // acc holds {partial product, remaining multiplier} or {unused, dividend/quotient}
    assign msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    assign shl    = {rem, acc[WIDTH-1]};
    assign diff   = shl - {1'b0, m};

    mdu_sign_fix #(.W(WIDTH))   u_abs_rs (.a(rs),  .neg(sgn && rs[WIDTH-1]), .y(rs_abs));
    mdu_sign_fix #(.W(WIDTH))   u_abs_rt (.a(rt),  .neg(sgn && rt[WIDTH-1]), .y(rt_abs));
    mdu_sign_fix #(.W(2*WIDTH)) u_fix_acc(.a(acc), .neg(neg_q),               .y(acc_fix));
    mdu_sign_fix #(.W(WIDTH))   u_fix_rem(.a(rem), .neg(neg_r),               .y(rem_fix));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            is_mul <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            m      <= '0;
            rem    <= '0;
            acc    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (mul_op || div_op)) begin
                        state  <= CALC;
                        cnt    <= '0;
                        is_mul <= mul_op;
                        m      <= mul_op ? rs_abs : rt_abs;
                        acc    <= {{WIDTH{1'b0}}, mul_op ? rt_abs : rs_abs};
                        rem    <= '0;
                        // divide by zero keeps the all-ones quotient unsigned
                        neg_q  <= sgn && (rs[WIDTH-1] ^ rt[WIDTH-1]) && (mul_op || rt != '0);
                        neg_r  <= sgn && rs[WIDTH-1];
                    end else if (start && op == OP_MTHI) begin
                        hi <= rs;
                    end else if (start && op == OP_MTLO) begin
                        lo <= rs;
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (is_mul) begin
                        acc <= {msum, acc[WIDTH-1:1]};
                    end else begin
                        rem            <= diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
                        acc[WIDTH-1:0] <= {acc[WIDTH-2:0], !diff[WIDTH]};
                    end
                    if (cnt == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    hi    <= is_mul ? acc_fix[2*WIDTH-1:WIDTH] : rem_fix;
                    lo    <= acc_fix[WIDTH-1:0];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with the architectural HI/LO registers for the single-cycle MIPS core.
- Sits beside the ALU, downstream of the decoder/register file. It consumes rs/rt operands and an op code, and produces HI/LO for MFHI/MFLO.
- Long operations raise busy so the core's control can stall the PC. MTHI/MTLO complete in one cycle.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  request strobe, sampled on rising clock
op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
rs  input  WIDTH  operand A (multiplicand / dividend / MTHI-MTLO source)
rt  input  WIDTH  operand B (multiplier / divisor)
busy  output  1  high while MULT/DIV in progress
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state=IDLE, busy=0, hi=0, lo=0, counter=0, operation aborted.
- State machine IDLE -> CALC -> FIX -> IDLE. busy=1 whenever state != IDLE, decoded from the state register.
- IDLE, start=1, op 1-4 at edge N:
  - latch absolute values of operands; signed ops only, unsigned ops pass through;
  - latch result-sign flags and op;
  - counter=0; state=CALC.
- CALC: one iteration per cycle.
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, remainder WIDTH+1 bits.
  - After WIDTH iterations, at edge N+WIDTH, state=FIX.
- FIX (one cycle): apply two's-complement sign correction, write hi/lo at edge N+WIDTH+1, state=IDLE.
- Timing: busy is high for exactly WIDTH+1 cycles (33). New hi/lo are visible in the first cycle busy is low.
- Multiply results: hi = upper WIDTH bits, lo = lower WIDTH bits of the full product.
  - MULT is signed; MULTU is unsigned.
- Divide results: lo = quotient, hi = remainder.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIVU is unsigned.
- Divide by zero (rt=0, DIV or DIVU): no error. Result lo=all ones, hi=rs. Still takes the full WIDTH+1 cycles.
- Signed overflow (DIV of 0x80000000 by 0xFFFFFFFF): lo=0x80000000, hi=0.
- MTHI/MTLO in IDLE: hi (resp. lo) <= rs at the same edge; busy stays 0; the other register is unchanged.
- Requests while busy: start with any op is ignored. The core is required to stall, so no queueing. hi/lo hold their old values until FIX.
- Operand stability: rs/rt are needed only at the start edge; later changes have no effect.
- hi/lo change only at FIX edges, MTHI/MTLO edges, or reset.
- Back-to-back: start may be asserted in the first cycle busy is low; the new operation begins immediately.

Decomposition:
- Shared package (mips constants include): the op codes, WIDTH default, and the state encodings IDLE/CALC/FIX.
- One natural sub-module, mdu_sign_fix: combinational abs-value and negate helpers, used both at operand latch and in the FIX stage.
- Top level holds the FSM, counter, accumulator and the HI/LO registers.

Test Plan:
- MULT rs=0xFFFFFFFF rt=0x00000002 -> busy high 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU, same operands -> hi=0x00000001, lo=0xFFFFFFFE. DIVU rs=100 rt=7 -> lo=0x0000000E, hi=0x00000002.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV rs=0x80000000 rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=0x12345678 rt=0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x12345678.
- MTHI rs=0xA5A5A5A5 -> hi updated next edge, busy never rises, lo unchanged. Then MTLO during a running DIV -> ignored, lo becomes the DIV quotient.
- Start MULT, assert reset at cycle 10 -> busy=0, hi=lo=0 immediately (asynchronous). After release, a new MULTU 3*5 -> lo=15, hi=0.
